// File: rtl/channel_frame_arbiter_if.sv
// Channel-select write port: ap_fifo-style suppress word, write strobe and space flag.
// The arbiter drives it as master and the channel-select stage is the slave.
interface channel_frame_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] sel_din;
  logic              sel_full_n;
  logic              sel_write;

  modport master (output sel_din, output sel_write, input sel_full_n);
  modport slave  (input sel_din, input sel_write, output sel_full_n);
endinterface

// File: rtl/channel_frame_arbiter.sv
// Frame-granular round-robin scheduler driving the 4-bit channel suppress word.
// Define CHFA_STATS_EN to add per-channel grant and timeout-revoke counters.
module channel_frame_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int TIMEOUT_W = 16,
  parameter int ID_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH-1:0]    frame_done,
  input  logic [NUM_CH-1:0]    halt_evt,
  input  logic [NUM_CH-1:0]    halt_clr,
  input  logic [NUM_CH-1:0]    err_clr,
  input  logic [7:0]           frames_per_grant,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  channel_frame_arbiter_if.master sel,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id,
  output logic [NUM_CH-1:0]    halted,
  output logic [NUM_CH-1:0]    timeout_err
`ifdef CHFA_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [NUM_CH*16-1:0] stats_grant,
  output logic [NUM_CH*16-1:0] stats_tmo
`endif
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_GRANT, S_ACTIVE, S_REVOKE} state_t;

  state_t               state;
  logic [7:0]           fpg_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [7:0]           frame_cnt;
  logic [TIMEOUT_W-1:0] cyc_cnt;

  logic [NUM_CH-1:0] eligible;
  logic [ID_W-1:0]   next_id;
  logic [ID_W-1:0]   probe;
  logic              found;
  logic              write_ok;
  logic [8:0]        frame_sum;
  logic              hit_frames, hit_halt, hit_tmo, revoke_now, tmo_set;
  logic [NUM_CH-1:0] tmo_set_vec;
  logic [NUM_CH-1:0] one_hot_lsb;

  assign one_hot_lsb = {{(NUM_CH-1){1'b0}}, 1'b1};

  // Strobe follows full_n combinationally so a write lands in the same cycle space appears.
  assign write_ok = !reset && sel.sel_full_n &&
                    (state == S_INIT || state == S_GRANT || state == S_REVOKE);
  assign sel.sel_write = write_ok;

  assign eligible = req & ~halted;

  // Circular search for the first eligible channel after the last grant.
  always_comb begin
    next_id = grant_id;
    found   = 1'b0;
    probe   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      probe = ID_W'((int'(grant_id) + k) % NUM_CH);
      if (!found && eligible[probe]) begin
        next_id = probe;
        found   = 1'b1;
      end
    end
  end

  assign frame_sum   = {1'b0, frame_cnt} + {8'd0, frame_done[grant_id]};
  assign hit_frames  = frame_sum >= {1'b0, fpg_q};
  assign hit_halt    = halted[grant_id] | halt_evt[grant_id];
  assign hit_tmo     = (tmo_q != '0) && (cyc_cnt == tmo_q - TIMEOUT_W'(1));
  assign revoke_now  = (state == S_ACTIVE) && (hit_frames || hit_halt || hit_tmo);
  assign tmo_set     = (state == S_ACTIVE) && hit_tmo && !hit_frames;
  assign tmo_set_vec = tmo_set ? (one_hot_lsb << grant_id) : '0;

  // NOTE: all state, including the latched grant parameters, uses non-blocking
  // assignments and is reset so a mid-frame reset leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      grant_id    <= ID_W'(NUM_CH - 1);
      grant_valid <= 1'b0;
      halted      <= '0;
      timeout_err <= '0;
      sel.sel_din <= '1;
      fpg_q       <= 8'd1;
      tmo_q       <= '0;
      frame_cnt   <= '0;
      cyc_cnt     <= '0;
    end else begin
      halted      <= (halted & ~halt_clr) | halt_evt;
      timeout_err <= (timeout_err & ~err_clr) | tmo_set_vec;
      unique case (state)
        S_INIT: begin
          if (write_ok) state <= S_IDLE;
        end
        S_IDLE: begin
          if (found) begin
            grant_id    <= next_id;
            sel.sel_din <= ~(one_hot_lsb << next_id);
            state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          fpg_q <= (frames_per_grant == 8'd0) ? 8'd1 : frames_per_grant;
          tmo_q <= timeout_cycles;
          if (write_ok) begin
            frame_cnt   <= '0;
            cyc_cnt     <= '0;
            grant_valid <= 1'b1;
            state       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          frame_cnt <= frame_sum[7:0];
          if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + TIMEOUT_W'(1);
          if (revoke_now) begin
            grant_valid <= 1'b0;
            sel.sel_din <= '1;
            state       <= S_REVOKE;
          end
        end
        S_REVOKE: begin
          if (write_ok) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

`ifdef CHFA_STATS_EN
  logic grant_wr;
  assign grant_wr = write_ok && (state == S_GRANT);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
    logic [15:0] g_cnt;
    logic [15:0] t_cnt;
    always_ff @(posedge clk) begin
      if (reset || stats_clr) begin
        g_cnt <= '0;
        t_cnt <= '0;
      end else begin
        if (grant_wr && grant_id == ID_W'(i) && g_cnt != 16'hFFFF) g_cnt <= g_cnt + 16'd1;
        if (tmo_set_vec[i] && t_cnt != 16'hFFFF) t_cnt <= t_cnt + 16'd1;
      end
    end
    assign stats_grant[i*16 +: 16] = g_cnt;
    assign stats_tmo[i*16 +: 16]   = t_cnt;
  end
`endif

endmodule

// File: tb/tb_channel_frame_arbiter.sv
// Self-checking bench for channel_frame_arbiter: behavioural model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_channel_frame_arbiter;
  localparam int N = 4;
  localparam int P_INIT = 0, P_IDLE = 1, P_GRANT = 2, P_ACTIVE = 3, P_REVOKE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req, frame_done, halt_evt, halt_clr, err_clr;
  logic [7:0]   fpg;
  logic [15:0]  tmo;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [N-1:0] halted, timeout_err;

  channel_frame_arbiter_if #(.NUM_CH(N)) sel_if ();

  channel_frame_arbiter #(.NUM_CH(N), .TIMEOUT_W(16), .ID_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .frame_done       (frame_done),
    .halt_evt         (halt_evt),
    .halt_clr         (halt_clr),
    .err_clr          (err_clr),
    .frames_per_grant (fpg),
    .timeout_cycles   (tmo),
    .sel              (sel_if),
    .grant_valid      (grant_valid),
    .grant_id         (grant_id),
    .halted           (halted),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: where we are in the grant cycle, who holds it, and its budget.
  int         m_phase = P_INIT;
  int         m_last  = N - 1;
  logic [3:0] m_halted = '0, m_err = '0;
  int         m_fpg = 1, m_tmo = 0, m_frames = 0, m_age = 0;

  int n_checks = 0, n_pass = 0;
  logic [3:0] wr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic wr);
    logic [3:0] elig, setv;
    int done_cnt;
    bit a, b, c;
    if (reset) begin
      m_phase = P_INIT; m_last = N - 1; m_halted = '0; m_err = '0;
      return;
    end
    setv = '0;
    case (m_phase)
      P_INIT:   if (wr) m_phase = P_IDLE;
      P_IDLE: begin
        elig = req & ~m_halted;
        for (int k = 1; k <= N; k++) begin
          if (elig[(m_last + k) % N]) begin
            m_last  = (m_last + k) % N;
            m_phase = P_GRANT;
            break;
          end
        end
      end
      P_GRANT: if (wr) begin
        m_fpg = (fpg == 0) ? 1 : int'(fpg);
        m_tmo = int'(tmo);
        m_frames = 0; m_age = 0;
        m_phase = P_ACTIVE;
      end
      P_ACTIVE: begin
        done_cnt = m_frames + int'(frame_done[m_last]);
        a = done_cnt >= m_fpg;
        b = m_halted[m_last] || halt_evt[m_last];
        c = (m_tmo != 0) && (m_age == m_tmo - 1);
        if (c && !a) setv[m_last] = 1'b1;
        if (a || b || c) m_phase = P_REVOKE;
        m_frames = done_cnt;
        if (m_age < 65535) m_age++;
      end
      default:  if (wr) m_phase = P_IDLE;
    endcase
    m_err    = (m_err & ~err_clr) | setv;
    m_halted = (m_halted & ~halt_clr) | halt_evt;
  endtask

  // One clock: compare all outputs against the model, log writes, advance the model.
  task automatic cycle();
    logic exp_wr;
    logic [3:0] exp_din;
    #1;
    exp_wr  = !reset && sel_if.sel_full_n &&
              (m_phase == P_INIT || m_phase == P_GRANT || m_phase == P_REVOKE);
    exp_din = (m_phase == P_GRANT || m_phase == P_ACTIVE) ? ~(4'b0001 << m_last) : 4'hF;
    check("sel_write",   sel_if.sel_write, exp_wr);
    check("sel_din",     sel_if.sel_din, exp_din);
    check("grant_valid", grant_valid, (m_phase == P_ACTIVE));
    check("grant_id",    grant_id, m_last);
    check("halted",      halted, m_halted);
    check("timeout_err", timeout_err, m_err);
    if (sel_if.sel_write === 1'b1) wr_q.push_back(sel_if.sel_din);
    model_step(exp_wr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    frame_done = '0; halt_evt = '0; halt_clr = '0; err_clr = '0;
  endtask

  task automatic drain();
    int t;
    req = '0;
    for (t = 0; t < 60 && m_phase != P_IDLE; t++) begin
      frame_done = (m_phase == P_ACTIVE) ? (4'b0001 << m_last) : 4'b0000;
      cycle();
    end
    frame_done = '0;
    if (t >= 60) check("drain_timeout", t, 0);
  endtask

  task automatic wait_active();
    for (int t = 0; t < 30 && grant_valid !== 1'b1; t++) cycle();
    check("wait_active", grant_valid, 1'b1);
  endtask

  initial begin
    logic [3:0] exp_seq [10];
    logic [3:0] held;
    int n2, na, c7, ce;
    exp_seq = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF, 4'hE};
    req = '0; clear_pulses(); fpg = 8'd1; tmo = 16'd0; sel_if.sel_full_n = 1'b1;
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    cycle(); cycle();
    check("rst_sel_din", sel_if.sel_din, 4'hF);
    check("rst_grant_id", grant_id, 2'd3);
    check("rst_write", sel_if.sel_write, 1'b0);
    check("rst_grant_valid", grant_valid, 1'b0);

    // Round robin over all four channels, one frame each
    reset = 1'b0; wr_q.delete(); req = 4'hF;
    for (int t = 0; t < 100 && wr_q.size() < 10; t++) begin
      frame_done = (m_phase == P_ACTIVE) ? (4'b0001 << m_last) : 4'b0000;
      cycle();
    end
    frame_done = '0;
    check("rr_write_count", wr_q.size() >= 10, 1);
    for (int i = 0; i < 10 && i < wr_q.size(); i++) check($sformatf("rr_write%0d", i), wr_q[i], exp_seq[i]);
    drain();

    // Three frames per grant on channel 2 with noise on channel 1
    fpg = 8'd3; req = 4'b0100;
    wait_active();
    check("fpg3_id", grant_id, 2'd2);
    n2 = 0;
    for (int t = 0; t < 40 && grant_valid === 1'b1; t++) begin
      frame_done = 4'b0010 | ((t % 2 == 1) ? 4'b0100 : 4'b0000);
      if (frame_done[2]) n2++;
      cycle();
    end
    frame_done = '0;
    check("fpg3_frames", n2, 3);
    drain();

    // Timeout on channel 1 after exactly 10 ACTIVE cycles
    fpg = 8'd5; tmo = 16'd10; req = 4'b0010;
    wait_active();
    na = 0;
    while (na < 40 && grant_valid === 1'b1) begin na++; cycle(); end
    check("tmo_cycles", na, 10);
    check("tmo_err", timeout_err, 4'b0010);
    req = '0; err_clr = 4'b0010; cycle(); err_clr = '0;
    check("err_clr", timeout_err, 4'b0000);
    drain();

    // Last frame on the timeout cycle: completion wins, no error
    fpg = 8'd1; req = 4'b0010;
    wait_active();
    na = 0;
    while (na < 40 && grant_valid === 1'b1) begin
      frame_done = (na == 9) ? 4'b0010 : 4'b0000;
      na++; cycle();
    end
    frame_done = '0;
    check("tmo_tie_cycles", na, 10);
    check("tmo_tie_err", timeout_err, 4'b0000);
    drain();

    // Halt on channel 3 revokes immediately and excludes it until cleared
    tmo = 16'd0; fpg = 8'd8; req = 4'b1000;
    wait_active();
    cycle(); cycle();
    halt_evt = 4'b1000; cycle(); halt_evt = '0;
    check("halt_revoke", grant_valid, 1'b0);
    check("halt_sticky", halted, 4'b1000);
    fpg = 8'd1; req = 4'b1001; wr_q.delete();
    for (int t = 0; t < 30; t++) begin
      frame_done = (m_phase == P_ACTIVE) ? (4'b0001 << m_last) : 4'b0000;
      cycle();
    end
    c7 = 0; ce = 0;
    foreach (wr_q[i]) begin if (wr_q[i] == 4'h7) c7++; if (wr_q[i] == 4'hE) ce++; end
    check("halt_skip", c7, 0);
    check("halt_other_served", ce > 0, 1);
    frame_done = (m_phase == P_ACTIVE) ? (4'b0001 << m_last) : 4'b0000;
    halt_clr = 4'b1000; cycle(); halt_clr = '0;
    check("halt_clr", halted, 4'b0000);
    wr_q.delete();
    for (int t = 0; t < 30; t++) begin
      frame_done = (m_phase == P_ACTIVE) ? (4'b0001 << m_last) : 4'b0000;
      cycle();
    end
    c7 = 0;
    foreach (wr_q[i]) if (wr_q[i] == 4'h7) c7++;
    check("halt_resume", c7 > 0, 1);
    drain();

    // Back-pressure in GRANT, then reset while ACTIVE
    sel_if.sel_full_n = 1'b0; fpg = 8'd4; req = 4'b0001;
    for (int t = 0; t < 10 && sel_if.sel_din === 4'hF; t++) cycle();
    held = sel_if.sel_din;
    check("bp_grant_word", held, 4'b1110);
    for (int t = 0; t < 5; t++) begin
      cycle();
      check("bp_hold_din", sel_if.sel_din, held);
      check("bp_no_write", sel_if.sel_write, 1'b0);
    end
    sel_if.sel_full_n = 1'b1; #1;
    check("bp_release_write", sel_if.sel_write, 1'b1);
    cycle();
    check("bp_active", grant_valid, 1'b1);
    reset = 1'b1; cycle(); cycle();
    reset = 1'b0; #1;
    check("reinit_write", sel_if.sel_write, 1'b1);
    check("reinit_din", sel_if.sel_din, 4'hF);
    check("reinit_gv", grant_valid, 1'b0);
    cycle();

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      reset      = ($urandom_range(0, 299) == 0);
      req        = 4'($urandom);
      frame_done = ((m_phase == P_ACTIVE && $urandom_range(0, 2) == 0) ? (4'b0001 << m_last) : 4'b0000)
                   | (($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000);
      halt_evt   = ($urandom_range(0, 39) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
      halt_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      err_clr    = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      fpg        = 8'($urandom_range(0, 3));
      tmo        = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      sel_if.sel_full_n = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
